// File: rtl/router_arbiter_if.sv
// Handshake bundle between the four requesters and the router arbiter.
// The arbiter takes the slave view. The requester side or testbench takes the master view.
interface router_arbiter_if;
  logic [3:0] req;
  logic [7:0] dest;
  logic [3:0] grant;
  logic [1:0] sender;
  logic [1:0] receiver;
  logic       busy;

  modport master (output req, dest, input grant, sender, receiver, busy);
  modport slave  (input req, dest, output grant, sender, receiver, busy);
endinterface

// File: rtl/router_arbiter.sv
// Round-robin arbiter/sequencer for the 4-port router.
// It drives registered grant and sender/receiver selects, and bounds each grant to MAX_HOLD cycles.
module router_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              reset,
  router_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sender_q, sender_d;
  logic [1:0]       receiver_q, receiver_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  // The search starts one past the last-served requester, so a requester that was just served goes last.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sender_d   = sender_q;
    receiver_d = receiver_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_GRANT;
          grant_d    = 4'b0001 << pick;
          sender_d   = pick;
          receiver_d = bus.dest[{pick, 1'b0} +: 2];
          cnt_d      = CNT_W'(1);
          ptr_d      = pick;
        end
      end
      S_GRANT: begin
        // On release, sender/receiver keep their values. The forced IDLE cycle is the router turnaround bubble.
        if (!bus.req[sender_q] || cnt_q == HOLD_LIM) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= 4'b0000;
      sender_q   <= 2'd0;
      receiver_q <= 2'd0;
      cnt_q      <= '0;
      ptr_q      <= 2'd3;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sender_q   <= sender_d;
      receiver_q <= receiver_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sender   = sender_q;
  assign bus.receiver = receiver_q;
  assign bus.busy     = (state_q == S_GRANT);

endmodule

// File: tb/tb_router_arbiter.sv
// Scoreboard bench for router_arbiter: a cycle model queues expected outputs per edge,
// and directed checks confirm round-robin order, hold length and dest latching.
module tb_router_arbiter;

  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic [1:0] r;
    logic       b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  router_arbiter_if bus ();

  router_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbq[$];

  int         m_own;
  int         m_cnt;
  int         m_ptr;
  logic [1:0] m_send;
  logic [1:0] m_recv;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_cnt  = 0;
    m_ptr  = 3;
    m_send = 2'd0;
    m_recv = 2'd0;
  endtask

  // Advance the reference model across one clock edge with the given inputs.
  task automatic model_edge(input logic [3:0] r, input logic [7:0] d);
    int  c;
    bit  done;
    if (m_own < 0) begin
      done = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!done && r[c]) begin
          done   = 1;
          m_own  = c;
          m_cnt  = 1;
          m_ptr  = c;
          m_send = 2'(c);
          m_recv = d[2*c +: 2];
        end
      end
    end else if (!r[m_own] || m_cnt == MAX_HOLD) begin
      m_own = -1;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
    e.s = m_send;
    e.r = m_recv;
    e.b = (m_own >= 0);
    return e;
  endfunction

  // Drive one cycle of stimulus, queue the expected result, then compare it after the edge.
  task automatic step(input logic [3:0] r, input logic [7:0] d);
    exp_t e;
    bus.req  = r;
    bus.dest = d;
    model_edge(r, d);
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("grant",    32'(bus.grant),    32'(e.g));
      chk("sender",   32'(bus.sender),   32'(e.s));
      chk("receiver", 32'(bus.receiver), 32'(e.r));
      chk("busy",     32'(bus.busy),     32'(e.b));
      chk("onehot0",  32'($onehot0(bus.grant)), 32'd1);
      chk("busy_or",  32'(bus.busy),     32'(|bus.grant));
    end
  endtask

  int   owners[$];
  int   lens[$];
  int   run;
  int   highs;
  logic [3:0] prev_g;

  initial begin
    bus.req  = 4'b0000;
    bus.dest = 8'h00;
    reset    = 1'b1;
    model_reset();
    #12;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single requester 2 to output 1, held three cycles.
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 8'b0001_0000);
      chk("single_g", 32'(bus.grant), 32'h4);
      chk("single_r", 32'(bus.receiver), 32'd1);
    end
    step(4'b0000, 8'h00);
    chk("single_rel", 32'(bus.busy), 32'd0);
    step(4'b0000, 8'h00);

    // Asynchronous reset in the middle of a grant.
    step(4'b1111, 8'hFF);
    step(4'b1111, 8'hFF);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_grant", 32'(bus.grant),    32'd0);
    chk("arst_busy",  32'(bus.busy),     32'd0);
    chk("arst_send",  32'(bus.sender),   32'd0);
    chk("arst_recv",  32'(bus.receiver), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin with all four requesting: 0,1,2,3,0, each MAX_HOLD long.
    prev_g = 4'b0000;
    run = 0;
    for (int i = 0; i < 44; i++) begin
      step(4'b1111, 8'hE4);
      if (bus.grant != 4'b0000 && prev_g == 4'b0000) owners.push_back(int'(bus.sender));
      if (bus.grant != 4'b0000) run++;
      else if (run != 0) begin lens.push_back(run); run = 0; end
      prev_g = bus.grant;
    end
    chk("rr_count", 32'(owners.size()), 32'd5);
    for (int i = 0; i < 5 && i < owners.size(); i++) chk("rr_owner", 32'(owners[i]), 32'(i % 4));
    chk("rr_runs", 32'(lens.size()), 32'd4);
    foreach (lens[i]) chk("rr_len", 32'(lens[i]), 32'(MAX_HOLD));
    step(4'b0000, 8'h00);
    step(4'b0000, 8'h00);

    // Sole requester 1 for 20 cycles: the hold limit forces one-cycle bubbles.
    highs = 0;
    for (int i = 1; i <= 20; i++) begin
      step(4'b0010, 8'h00);
      chk("sole_g", 32'(bus.grant), ((i - 1) % 9 == 8) ? 32'h0 : 32'h2);
      if (bus.grant != 4'b0000) highs++;
    end
    chk("sole_highs", 32'(highs), 32'd18);
    step(4'b0000, 8'h00);
    chk("sole_drop", 32'(bus.grant), 32'd0);

    // A dest change during a grant is ignored until the next grant.
    step(4'b0001, 8'h03);
    step(4'b0001, 8'h03);
    step(4'b0001, 8'h02);
    chk("dest_hold", 32'(bus.receiver), 32'd3);
    step(4'b0001, 8'h02);
    chk("dest_hold2", 32'(bus.receiver), 32'd3);
    step(4'b0000, 8'h02);
    chk("dest_keep", 32'(bus.receiver), 32'd3);
    step(4'b0001, 8'h02);
    chk("dest_new", 32'(bus.receiver), 32'd2);
    step(4'b0000, 8'h00);

    // After requester 2 is served, requester 0 wins over 2.
    step(4'b0100, 8'h00);
    step(4'b0100, 8'h00);
    step(4'b0000, 8'h00);
    step(4'b0101, 8'h00);
    chk("prio_after", 32'(bus.grant), 32'h1);
    step(4'b0000, 8'h00);

    // Random traffic under the model.
    for (int i = 0; i < 80; i++) step(4'($urandom_range(0, 15)), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
